// File: rtl/ram_port_arbiter.sv
// Purpose  : round-robin arbiter, with per-requester lock, for the single-port 64x8 data RAM.
// Latency  : a request is granted one cycle later at the earliest; read data arrives one cycle after the grant.
// Backpress: a requester holds req until gnt arrives; a held lock can starve the other requester
//            unless ARB_LOCK_LIMIT_EN caps the run length.
//
// Requester 0 is the processor core and requester 1 is the host/debug port.
// The arbiter performs one RAM access per cycle.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset (0 = reset)
//   req0/1, lock0/1           access request, and keep-grant request
//   we0/1, addr0/1, wdata0/1  access attributes, held stable while req is high
//   gnt0/1                    registered; the access is performed this cycle
//   rvalid0/1                 registered; rdata holds read data for that requester
//   rdata                     shared read data bus (tracks ram_rdata)
//   ram_wren/addr/wdata       RAM control, muxed from the granted requester
//   ram_rdata                 RAM read data, one cycle after the address
//
// Build option
//   ARB_LOCK_LIMIT_EN: a locked requester keeps the grant for at most HOLD_MAX
//   consecutive cycles while the other requester waits.
module ram_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
`ifdef ARB_LOCK_LIMIT_EN
  , parameter int HOLD_MAX = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_wren,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_last;   // index of the most recently granted requester
  logic   last_idx;  // the grant in progress counts as the most recent one
  logic   brk0;      // lock0 is overridden by the hold limit
  logic   brk1;      // lock1 is overridden by the hold limit

`ifdef ARB_LOCK_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  // Counts consecutive grant cycles to the current owner, including this cycle.
  logic [CW-1:0] hold_cnt;

  assign brk0 = (hold_cnt >= CW'(HOLD_MAX)) && req1;
  assign brk1 = (hold_cnt >= CW'(HOLD_MAX)) && req0;
`else
  assign brk0 = 1'b0;
  assign brk1 = 1'b0;
`endif

  always_comb begin
    last_idx = rr_last;
    if (state == G0) begin
      last_idx = 1'b0;
    end else if (state == G1) begin
      last_idx = 1'b1;
    end

    state_nxt = IDLE;
    if ((state == G0) && lock0 && req0 && !brk0) begin
      state_nxt = G0;
    end else if ((state == G1) && lock1 && req1 && !brk1) begin
      state_nxt = G1;
    end else if (req0 && req1) begin
      state_nxt = last_idx ? G0 : G1;
    end else if (req0) begin
      state_nxt = G0;
    end else if (req1) begin
      state_nxt = G1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rr_last <= 1'b1;  // after reset, a tie goes to requester 0
`ifdef ARB_LOCK_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      gnt0    <= (state_nxt == G0);
      gnt1    <= (state_nxt == G1);
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (state == G0) begin
        rr_last <= 1'b0;
      end else if (state == G1) begin
        rr_last <= 1'b1;
      end
`ifdef ARB_LOCK_LIMIT_EN
      if (state_nxt == IDLE) begin
        hold_cnt <= '0;
      end else if (state_nxt != state) begin
        hold_cnt <= CW'(1);
      end else if (hold_cnt < CW'(HOLD_MAX)) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
`endif
    end
  end

  // The RAM port follows the registered state only, so there is no
  // combinational path from req to the RAM.
  always_comb begin
    ram_wren  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      G0: begin
        ram_wren  = we0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
      end
      G1: begin
        ram_wren  = we1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
      end
      default: ;
    endcase
  end

  assign rdata = ram_rdata;

endmodule
